// File: rtl/acd_pkg.sv
// Shared types and field positions for the ACD bus responder.
`timescale 1ns/1ps
package acd_pkg;
  localparam int unsigned ACD_W   = 16;
  localparam int unsigned ADDR_W  = 24;
  localparam int unsigned WE_BIT  = 8;
  localparam int unsigned LEN_LSB = 9;
  localparam int unsigned LEN_MSB = 10;
  localparam int unsigned LEN_W   = LEN_MSB - LEN_LSB + 1;

  typedef enum logic [2:0] {
    IDLE,
    ADDR_HI,
    WR_DATA,
    WR_MEM,
    RD_MEM,
    RD_DRIVE
  } acd_state_e;
endpackage

// File: rtl/acd_sync.sv
// N-stage synchroniser for W async inputs; rising-edge detect on bit 0 (pclk).
`timescale 1ns/1ps
module acd_sync #(
  parameter int unsigned N = 2,
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_async,
  output logic [W-1:0] o_sync,
  output logic         o_rise
);
  logic [W-1:0] r_stage [N];
  logic         r_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stage <= '{default: '0};
      r_prev  <= 1'b0;
    end else begin
      r_stage[0] <= i_async;
      for (int unsigned i = 1; i < N; i++) r_stage[i] <= r_stage[i-1];
      r_prev <= r_stage[N-1][0];
    end
  end

  assign o_sync = r_stage[N-1];
  assign o_rise = r_stage[N-1][0] & ~r_prev;
endmodule

// File: rtl/acd_bus_responder.sv
// ACD bus memory-side responder: decodes PRQ requests and runs word transfers to SRAM.
// Optional mem_ack timeout enabled by defining ACD_TIMEOUT_EN.
`timescale 1ns/1ps
module acd_bus_responder
  import acd_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned MAX_WORDS      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pclk,
  input  logic              prq,
  input  logic              bout,
  input  logic [ACD_W-1:0]  acd_in,
  output logic [ACD_W-1:0]  acd_out,
  output logic              acd_oe,
  output logic              acd_rdy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ACD_W-1:0]  mem_wdata,
  input  logic [ACD_W-1:0]  mem_rdata,
  input  logic              mem_ack,
  output logic              bus_err
);
  logic w_tick, w_prq_s, w_bout_s, w_unused_pclk_lvl;

  acd_sync #(.N(SYNC_STAGES), .W(3)) u_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async ({bout, prq, pclk}),
    .o_sync  ({w_bout_s, w_prq_s, w_unused_pclk_lvl}),
    .o_rise  (w_tick)
  );

  acd_state_e        r_state, w_state;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic [LEN_W-1:0]  r_left, w_left;
  logic [ACD_W-1:0]  r_wdata, w_wdata, r_acd_out, w_acd_out;
  logic              r_phase, w_phase, r_req, w_req, r_we, w_we;
  logic              r_oe, w_oe, r_rdy, w_rdy, r_err, w_err;
  logic [LEN_W:0]    w_words;

  assign w_words = {1'b0, acd_in[LEN_MSB:LEN_LSB]} + 1'b1;

`ifdef ACD_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] r_tmo, w_tmo;
  logic             w_tmo_hit;
  assign w_tmo_hit = r_req && !mem_ack && (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYCLES == 0);
`endif

  always_comb begin
    w_state   = r_state;
    w_addr    = r_addr;
    w_left    = r_left;
    w_phase   = r_phase;
    w_req     = r_req;
    w_we      = r_we;
    w_wdata   = r_wdata;
    w_acd_out = r_acd_out;
    w_oe      = r_oe;
    w_rdy     = r_rdy;
    w_err     = r_err;
    // acd_rdy spans exactly one pclk period: every tick clears it unless re-armed below
    if (w_tick) w_rdy = 1'b0;
    case (r_state)
      IDLE: begin
        w_phase = 1'b0;
        if (w_tick && w_prq_s) begin
          w_addr[ACD_W-1:0] = acd_in;
          w_state           = ADDR_HI;
        end
      end
      ADDR_HI: if (w_tick) begin
        w_addr[ADDR_W-1:ACD_W] = acd_in[ADDR_W-ACD_W-1:0];
        w_left                 = acd_in[LEN_MSB:LEN_LSB];
        if (32'(w_words) > MAX_WORDS) begin
          w_err   = 1'b1;
          w_state = IDLE;
        end else if (acd_in[WE_BIT]) w_state = WR_DATA;
        else                         w_state = RD_MEM;
      end
      WR_DATA: if (w_tick && w_bout_s) begin
        w_wdata = acd_in;
        w_state = WR_MEM;
      end
      WR_MEM: begin
        // r_phase marks "ack received, waiting for the tick that acknowledges the processor"
        if (!r_phase && !r_req) begin
          w_req = 1'b1;
          w_we  = 1'b1;
        end else if (r_req && mem_ack) begin
          w_req   = 1'b0;
          w_phase = 1'b1;
        end else if (r_phase && w_tick) begin
          w_rdy   = 1'b1;
          w_phase = 1'b0;
          w_addr  = r_addr + 1'b1;
          if (r_left == '0) w_state = IDLE;
          else begin
            w_left  = r_left - 1'b1;
            w_state = WR_DATA;
          end
        end
      end
      RD_MEM: begin
        if (!r_req) begin
          w_req = 1'b1;
          w_we  = 1'b0;
        end else if (mem_ack) begin
          w_req     = 1'b0;
          w_acd_out = mem_rdata;
          w_state   = RD_DRIVE;
        end
      end
      RD_DRIVE: if (w_tick) begin
        if (!r_phase) begin
          if (w_bout_s) begin
            w_err   = 1'b1;
            w_oe    = 1'b0;
            w_state = IDLE;
          end else begin
            w_oe    = 1'b1;
            w_rdy   = 1'b1;
            w_phase = 1'b1;
          end
        end else begin
          w_oe    = 1'b0;
          w_phase = 1'b0;
          w_addr  = r_addr + 1'b1;
          if (r_left == '0) w_state = IDLE;
          else begin
            w_left  = r_left - 1'b1;
            w_state = RD_MEM;
          end
        end
      end
      default: w_state = IDLE;
    endcase
`ifdef ACD_TIMEOUT_EN
    w_tmo = '0;
    if (r_req && !mem_ack) w_tmo = r_tmo + 1'b1;
    if (w_tmo_hit) begin
      w_req   = 1'b0;
      w_err   = 1'b1;
      w_oe    = 1'b0;
      w_phase = 1'b0;
      w_tmo   = '0;
      w_state = IDLE;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_left    <= '0;
      r_phase   <= 1'b0;
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_wdata   <= '0;
      r_acd_out <= '0;
      r_oe      <= 1'b0;
      r_rdy     <= 1'b0;
      r_err     <= 1'b0;
`ifdef ACD_TIMEOUT_EN
      r_tmo     <= '0;
`endif
    end else begin
      r_state   <= w_state;
      r_addr    <= w_addr;
      r_left    <= w_left;
      r_phase   <= w_phase;
      r_req     <= w_req;
      r_we      <= w_we;
      r_wdata   <= w_wdata;
      r_acd_out <= w_acd_out;
      r_oe      <= w_oe;
      r_rdy     <= w_rdy;
      r_err     <= w_err;
`ifdef ACD_TIMEOUT_EN
      r_tmo     <= w_tmo;
`endif
    end
  end

  assign acd_out   = r_acd_out;
  assign acd_oe    = r_oe;
  assign acd_rdy   = r_rdy;
  assign mem_req   = r_req;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign bus_err   = r_err;
endmodule

// File: tb/tb_acd_bus_responder.sv
// Scoreboard bench for acd_bus_responder: processor/SRAM models plus output monitors.
`timescale 1ns/1ps
module tb_acd_bus_responder;
  logic        clk = 1'b0, rst = 1'b1, pclk = 1'b0, prq = 1'b0, bout = 1'b0;
  logic [15:0] acd_in = 16'h0, mem_rdata = 16'h0;
  logic        mem_ack = 1'b0;
  logic [15:0] acd_out, mem_wdata;
  logic [23:0] mem_addr;
  logic        acd_oe, acd_rdy, mem_req, mem_we, bus_err;

  acd_bus_responder #(.SYNC_STAGES(2), .MAX_WORDS(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .pclk(pclk), .prq(prq), .bout(bout), .acd_in(acd_in),
    .acd_out(acd_out), .acd_oe(acd_oe), .acd_rdy(acd_rdy), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_err(bus_err)
  );

  always #5  clk  = ~clk;
  always #40 pclk = ~pclk;

  typedef struct packed {
    logic        we;
    logic [23:0] addr;
    logic [15:0] data;
  } mem_exp_t;

  mem_exp_t    exp_mem[$];
  logic [15:0] exp_rd[$];
  logic [15:0] mem [logic [23:0]];
  int          total = 0, bad = 0, rdy_pulses = 0;
  logic        ack_en = 1'b1, late_ack = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // SRAM model: acks a request two cycles after it is seen
  initial begin : mem_model
    int unsigned dly;
    dly = 0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (late_ack) begin
        mem_ack  = 1'b1;
        late_ack = 1'b0;
      end else if (mem_req && ack_en) begin
        if (dly == 2) begin
          dly     = 0;
          mem_ack = 1'b1;
          if (mem_we) mem[mem_addr] = mem_wdata;
          else mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 16'h0;
        end else dly++;
      end else dly = 0;
    end
  end

  // Output monitor: pops expectations whenever the DUT presents a request or drives ACD
  logic prev_req = 1'b0, prev_oe = 1'b0, prev_rdy = 1'b0;
  int   oe_len = 0, rdy_len = 0;
  always @(negedge clk) begin
    if (mem_req && !prev_req) begin
      if (exp_mem.size() == 0) begin
        total++; bad++;
        $display("FAIL mem_req_unexpected: got addr %0h expected no request", mem_addr);
      end else begin
        mem_exp_t e;
        e = exp_mem.pop_front();
        check("mem_we", {31'h0, mem_we}, {31'h0, e.we});
        check("mem_addr", {8'h0, mem_addr}, {8'h0, e.addr});
        if (e.we) check("mem_wdata", {16'h0, mem_wdata}, {16'h0, e.data});
      end
    end
    if (acd_oe && !prev_oe) begin
      if (exp_rd.size() == 0) begin
        total++; bad++;
        $display("FAIL acd_oe_unexpected: got acd_out %0h expected no drive", acd_out);
      end else check("acd_out", {16'h0, acd_out}, {16'h0, exp_rd.pop_front()});
    end
    if (acd_oe) oe_len++;
    else if (prev_oe) begin
      check("oe_width", oe_len, 8);
      oe_len = 0;
    end
    if (acd_rdy && !prev_rdy) rdy_pulses++;
    if (acd_rdy) rdy_len++;
    else if (prev_rdy) begin
      check("rdy_width", rdy_len, 8);
      rdy_len = 0;
    end
    prev_req = mem_req;
    prev_oe  = acd_oe;
    prev_rdy = acd_rdy;
  end

  task automatic exp_m(input logic we, input logic [23:0] a, input logic [15:0] d);
    exp_mem.push_back('{we: we, addr: a, data: d});
  endtask

  task automatic hdr(input logic [23:0] a, input logic we, input logic [1:0] len);
    @(negedge pclk); prq = 1'b1; acd_in = a[15:0];
    @(negedge pclk); prq = 1'b0; acd_in = {5'b0, len, we, a[23:16]};
  endtask

  task automatic wait_rdy(input string name);
    int n;
    n = 0;
    do begin
      @(negedge pclk);
      n++;
    end while (!acd_rdy && n < 20);
    check(name, {31'h0, acd_rdy}, 32'h1);
  endtask

  task automatic wr_burst(input logic [15:0] d [4], input int n);
    @(negedge pclk); bout = 1'b1; acd_in = d[0];
    for (int i = 0; i < n; i++) begin
      wait_rdy("wr_rdy");
      if (i + 1 < n) acd_in = d[i+1];
    end
    bout = 1'b0;
  endtask

  task automatic rd_burst(input int n);
    for (int i = 0; i < n; i++) wait_rdy("rd_rdy");
  endtask

  task automatic check_rst(input string tag);
    check({tag, "_acd_out"}, {16'h0, acd_out}, 32'h0);
    check({tag, "_acd_oe"}, {31'h0, acd_oe}, 32'h0);
    check({tag, "_acd_rdy"}, {31'h0, acd_rdy}, 32'h0);
    check({tag, "_mem_req"}, {31'h0, mem_req}, 32'h0);
    check({tag, "_mem_we"}, {31'h0, mem_we}, 32'h0);
    check({tag, "_mem_addr"}, {8'h0, mem_addr}, 32'h0);
    check({tag, "_mem_wdata"}, {16'h0, mem_wdata}, 32'h0);
    check({tag, "_bus_err"}, {31'h0, bus_err}, 32'h0);
  endtask

  task automatic wait_req(input string name);
    int n;
    n = 0;
    while (!mem_req && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'h0, mem_req}, 32'h1);
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [15:0] wd [4];
    int          rdy0, n;
    mem[24'h561234] = 16'hBEEF;
    mem[24'hFFFFFF] = 16'hA5A5;
    mem[24'h000000] = 16'h5A5A;
    mem[24'h000100] = 16'h7777;

    repeat (5) @(negedge clk);
    check_rst("reset");
    rst = 1'b0;

    // 1: single-word read
    exp_m(1'b0, 24'h561234, 16'h0);
    exp_rd.push_back(16'hBEEF);
    hdr(24'h561234, 1'b0, 2'd0);
    rd_burst(1);
    repeat (16) @(negedge clk);
    check("t1_rdy_count", rdy_pulses, 1);
    check("t1_bus_err", {31'h0, bus_err}, 32'h0);

    // 2: four-word write crossing a 64K boundary
    wd = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    exp_m(1'b1, 24'h00FFFE, 16'h1111);
    exp_m(1'b1, 24'h00FFFF, 16'h2222);
    exp_m(1'b1, 24'h010000, 16'h3333);
    exp_m(1'b1, 24'h010001, 16'h4444);
    hdr(24'h00FFFE, 1'b1, 2'd3);
    wr_burst(wd, 4);
    repeat (16) @(negedge clk);
    check("t2_rdy_count", rdy_pulses, 5);
    check("t2_mem_q_empty", exp_mem.size(), 0);

    // 3: two-word read wrapping 0xFFFFFF -> 0x000000
    exp_m(1'b0, 24'hFFFFFF, 16'h0);
    exp_m(1'b0, 24'h000000, 16'h0);
    exp_rd.push_back(16'hA5A5);
    exp_rd.push_back(16'h5A5A);
    hdr(24'hFFFFFF, 1'b0, 2'd1);
    rd_burst(2);
    repeat (16) @(negedge clk);
    check("t3_bus_err", {31'h0, bus_err}, 32'h0);
    check("t3_rd_q_empty", exp_rd.size(), 0);

    // 4: processor still driving during RD_DRIVE
    exp_m(1'b0, 24'h000100, 16'h0);
    rdy0 = rdy_pulses;
    hdr(24'h000100, 1'b0, 2'd0);
    bout = 1'b1;
    repeat (4) @(negedge pclk);
    check("t4_bus_err", {31'h0, bus_err}, 32'h1);
    check("t4_acd_oe", {31'h0, acd_oe}, 32'h0);
    check("t4_rdy_count", rdy_pulses, rdy0);
    check("t4_mem_q_empty", exp_mem.size(), 0);
    bout = 1'b0;

    // 5: reset during WR_MEM, then a clean write/read at 0x000010
    ack_en = 1'b0;
    exp_m(1'b1, 24'h000200, 16'hDEAD);
    hdr(24'h000200, 1'b1, 2'd0);
    @(negedge pclk); bout = 1'b1; acd_in = 16'hDEAD;
    wait_req("t5_req_up");
    rst = 1'b1;
    @(negedge clk);
    check_rst("t5_rst");
    rst = 1'b0; bout = 1'b0; ack_en = 1'b1;
    rdy0 = rdy_pulses;
    wd = '{16'hCAFE, 16'h0, 16'h0, 16'h0};
    exp_m(1'b1, 24'h000010, 16'hCAFE);
    hdr(24'h000010, 1'b1, 2'd0);
    wr_burst(wd, 1);
    exp_m(1'b0, 24'h000010, 16'h0);
    exp_rd.push_back(16'hCAFE);
    hdr(24'h000010, 1'b0, 2'd0);
    rd_burst(1);
    repeat (16) @(negedge clk);
    check("t5_rdy_count", rdy_pulses, rdy0 + 2);
    check("t5_bus_err", {31'h0, bus_err}, 32'h0);

    // 6: mem_ack withheld
    ack_en = 1'b0;
    exp_m(1'b0, 24'h000300, 16'h0);
    hdr(24'h000300, 1'b0, 2'd0);
    wait_req("t6_req_up");
`ifdef ACD_TIMEOUT_EN
    n = 0;
    while (mem_req && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("t6_tmo_cycles", n, 16);
    check("t6_bus_err", {31'h0, bus_err}, 32'h1);
    rdy0 = rdy_pulses;
    late_ack = 1'b1;
    repeat (20) @(negedge clk);
    check("t6_late_req", {31'h0, mem_req}, 32'h0);
    check("t6_late_oe", {31'h0, acd_oe}, 32'h0);
    check("t6_late_rdy", rdy_pulses, rdy0);
    ack_en = 1'b1;
    exp_m(1'b0, 24'h000010, 16'h0);
    exp_rd.push_back(16'hCAFE);
    hdr(24'h000010, 1'b0, 2'd0);
    rd_burst(1);
    repeat (16) @(negedge clk);
`else
    n = 0;
    repeat (10000) @(negedge clk);
    check("t6_still_waiting", {31'h0, mem_req}, 32'h1);
    check("t6_bus_err", {31'h0, bus_err}, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; ack_en = 1'b1;
    repeat (4) @(negedge clk);
`endif
    check("end_mem_q_empty", exp_mem.size(), 0);
    check("end_rd_q_empty", exp_rd.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
